// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Two WIDTH-bit operands are added
//   BITS_PER_CYCLE bits per clock through a BITS_PER_CYCLE-wide ripple of
//   full-adder cells. The carry is held in a register between beats.
//   Operation takes one acceptance cycle, N = WIDTH/BITS_PER_CYCLE beats,
//   and then waits in DONE until the consumer takes the result.
//
// Parameters
//   WIDTH          operand/result width (>= 1)
//   BITS_PER_CYCLE bits per beat (1..WIDTH, must divide WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands
//   cin        carry-in (add mode only)
//   sub        0: a+b+cin, 1: a-b (a+~b+1)
//   out_valid  result available (DONE only)
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Build option
//   SERIAL_ADDER_OVF_EN : adds the ovf port and MSB carry-in tracking.

module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Guarded copy of the slice width so illegal values cannot break the
  // width expressions below before the $error fires.
  localparam int BPC   = (BITS_PER_CYCLE < 1) ? 1 :
                         (BITS_PER_CYCLE > WIDTH) ? WIDTH : BITS_PER_CYCLE;
  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 1 (got %0d)", WIDTH);
  end

  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH ||
      (WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("serial_adder: BITS_PER_CYCLE=%0d must be in 1..WIDTH and divide WIDTH=%0d",
           BITS_PER_CYCLE, WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Ripple slice over the low BPC bits of the operand shift registers.
  logic [BPC:0]       c;
  logic [BPC-1:0]     slice_sum;
  logic [WIDTH+BPC-1:0] acc_shift;
  logic [WIDTH-1:0]   acc_next;

  always_comb begin
    c         = '0;
    slice_sum = '0;
    c[0]      = carry_q;
    for (int unsigned i = 0; i < BPC; i++) begin
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]       = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New slice enters at the top; after N beats beat 0 has reached bit 0.
  assign acc_shift = {slice_sum, acc_q};
  assign acc_next  = acc_shift[WIDTH+BPC-1:BPC];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = CNT_W'(N - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        acc_d   = acc_next;
        carry_d = c[BPC];
        if (cnt_q == '0) begin
          // Final beat: publish into the held output registers so sum/cout
          // stay stable through DONE and after the handshake.
          sum_d   = acc_next;
          cout_d  = c[BPC];
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = c[BPC-1] ^ c[BPC];
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: three instances (8/1, 16/4, 1/1) driven with
// directed and random operations, checked against an arithmetic model.
// Define SERIAL_ADDER_OVF_EN for both files to exercise ovf.

module tb_serial_adder;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  // WIDTH=8, BPC=1
  logic       iv8, ir8, ov8, or8, cin8, sub8, co8;
  logic [7:0] a8, b8, s8;
  // WIDTH=16, BPC=4
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16;
  logic [15:0] a16, b16, s16;
  // WIDTH=1, BPC=1
  logic       iv1, ir1, ov1, or1, cin1, sub1, co1;
  logic [0:0] a1, b1, s1;
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf8, ovf16, ovf1;
`endif

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {ovf, cout, sum[15:0]} from plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic sub);
    longint mask, av, bv, c, full, half, sa, sb, s;
    logic   ov, co;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = sub ? (~longint'(b)) & mask : longint'(b) & mask;
    c    = sub ? 1 : (cin ? 1 : 0);
    full = av + bv + c;
    half = longint'(1) << (w - 1);
    sa   = (av >= half) ? av - 2 * half : av;
    sb   = (bv >= half) ? bv - 2 * half : bv;
    s    = sa + sb + c;
    ov   = (s >= half) || (s < -half);
    co   = ((full >> w) & 1) != 0;
    return {ov, co, 16'(full & mask)};
  endfunction

  task automatic drive(input int w, input logic iv, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic sub);
    case (w)
      8: begin
        iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub;
      end
      16: begin
        iv16 = iv; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
      end
      default: begin
        iv1 = iv; a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; sub1 = sub;
      end
    endcase
  endtask

  function automatic logic get_ir(input int w);
    case (w)
      8:       return ir8;
      16:      return ir16;
      default: return ir1;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      8:       return ov8;
      16:      return ov16;
      default: return ov1;
    endcase
  endfunction

  function automatic logic [15:0] get_sum(input int w);
    case (w)
      8:       return {8'h00, s8};
      16:      return s16;
      default: return {15'h0000, s1};
    endcase
  endfunction

  function automatic logic get_cout(input int w);
    case (w)
      8:       return co8;
      16:      return co16;
      default: return co1;
    endcase
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic get_ovf(input int w);
    case (w)
      8:       return ovf8;
      16:      return ovf16;
      default: return ovf1;
    endcase
  endfunction
`endif

  // One full operation with out_ready held high. Called at a negedge with
  // the selected instance idle; returns at the negedge after the handshake.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input string name);
    logic [17:0] exp;
    int          n;
    int          lat;
    lat = (w == 16) ? 4 : w;
    exp = model(w, a, b, cin, sub);
    total++;
    if (get_ir(w) !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_ready: in_ready=%b want 1", name, get_ir(w));
    end
    drive(w, 1'b1, a, b, cin, sub);
    @(negedge clk);
    // Operands need only be stable on the accepting edge.
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    n = 0;
    while (get_ov(w) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, n, lat);
    end
    total++;
    if (get_sum(w) !== exp[15:0]) begin
      bad++;
      $display("FAIL %s sum: got %h want %h", name, get_sum(w), exp[15:0]);
    end
    total++;
    if (get_cout(w) !== exp[16]) begin
      bad++;
      $display("FAIL %s cout: got %b want %b", name, get_cout(w), exp[16]);
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (get_ovf(w) !== exp[17]) begin
      bad++;
      $display("FAIL %s ovf: got %b want %b", name, get_ovf(w), exp[17]);
    end
`endif
    @(negedge clk);
    total++;
    if (get_ov(w) !== 1'b0 || get_ir(w) !== 1'b1) begin
      bad++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0/1",
               name, get_ov(w), get_ir(w));
    end
    total++;
    if (get_sum(w) !== exp[15:0] || get_cout(w) !== exp[16]) begin
      bad++;
      $display("FAIL %s post_hold: sum=%h cout=%b want %h/%b",
               name, get_sum(w), get_cout(w), exp[15:0], exp[16]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    or8 = 1'b1; or16 = 1'b1; or1 = 1'b1;
    drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(16, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_d8: ir=%b ov=%b sum=%h cout=%b want 1/0/00/0",
               ir8, ov8, s8, co8);
    end
    total++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || s16 !== 16'h0000 || co16 !== 1'b0) begin
      bad++;
      $display("FAIL reset_d16: ir=%b ov=%b sum=%h cout=%b want 1/0/0000/0",
               ir16, ov16, s16, co16);
    end
    total++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || s1 !== 1'b0 || co1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_d1: ir=%b ov=%b sum=%b cout=%b want 1/0/0/0",
               ir1, ov1, s1, co1);
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ovf8 !== 1'b0 || ovf16 !== 1'b0 || ovf1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b%b%b want 000", ovf8, ovf16, ovf1);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8, 16'h005A, 16'h003C, 1'b1, 1'b0, "add_5a_3c");
    run_op(8, 16'h00FF, 16'h0001, 1'b0, 1'b0, "wrap_ff_01");
    run_op(8, 16'h007F, 16'h0001, 1'b0, 1'b0, "ovf_7f_01");
    run_op(8, 16'h0010, 16'h0020, 1'b1, 1'b1, "sub_10_20");
    run_op(8, 16'h0080, 16'h0001, 1'b0, 1'b1, "sub_ovf_80_01");
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16_wrap");
    run_op(16, 16'h1234, 16'h1234, 1'b0, 1'b1, "w16_sub_eq");
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      run_op(1, 16'(i >> 2), 16'((i >> 1) & 1), 1'((i & 1) != 0), 1'b0, "w1_exh");
    end
    run_op(1, 16'h0000, 16'h0001, 1'b0, 1'b1, "w1_sub");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand8");
    end
    for (int i = 0; i < 10; i++) begin
      run_op(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] exp;
    int          n;
    exp = model(8, 16'h00C3, 16'h005E, 1'b1, 1'b0);
    or8 = 1'b0;
    drive(8, 1'b1, 16'h00C3, 16'h005E, 1'b1, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (ov8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL bp_latency: got %0d cycles want 8", n);
    end
    for (int k = 0; k < 5; k++) begin
      drive(8, 1'((k & 1) == 0), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      total++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || s8 !== exp[7:0] || co8 !== exp[16]) begin
        bad++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b sum=%h cout=%b want 1/0/%h/%b",
                 k, ov8, ir8, s8, co8, exp[7:0], exp[16]);
      end
    end
    drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
    or8 = 1'b1;
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: ov=%b ir=%b want 0/1", ov8, ir8);
    end
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || s8 !== exp[7:0]) begin
      bad++;
      $display("FAIL bp_idle: ov=%b ir=%b sum=%h want 0/1/%h", ov8, ir8, s8, exp[7:0]);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    run_op(8, 16'h00F0, 16'h00F0, 1'b1, 1'b0, "pre_reset");
    drive(8, 1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || ir8 !== 1'b1) begin
      bad++;
      $display("FAIL midop_reset: ov=%b sum=%h cout=%b ir=%b want 0/00/0/1",
               ov8, s8, co8, ir8);
    end
`ifdef SERIAL_ADDER_OVF_EN
    total++;
    if (ovf8 !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset_ovf: got %b want 0", ovf8);
    end
`endif
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov8 !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midop_no_result: out_valid high %0d cycles want 0", seen);
    end
    run_op(8, 16'h0001, 16'h0001, 1'b0, 1'b0, "post_reset_1p1");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_width1();
    test_random();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, multi-cycle successor to the single-bit dataflow full adder. It adds two WIDTH-bit operands BITS_PER_CYCLE bits per clock by iterating a BITS_PER_CYCLE-wide ripple of full-adder cells. Carry is held in a register between beats, and the block supports add and subtract modes. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and trades latency for area in the arithmetic datapath.

## Interface
- WIDTH, 8, operand and result width; must be ≥ 1.
- BITS_PER_CYCLE, 1, bits processed per beat; must be in 1..WIDTH and divide WIDTH exactly, otherwise elaboration fails via $error.
- Derived N = WIDTH / BITS_PER_CYCLE, the beat count.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset: synchronous and active-low.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a+~b+1 (a−b), cin ignored.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in subtract mode 1 means no borrow.
- ovf  out  1  signed overflow; exists only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1. Input handshake (in_valid & in_ready) captures a into shift register A and (sub ? ~b : b) into shift register B. The carry register is loaded with (sub ? 1 : cin), the beat counter is set to N−1, and the FSM goes to RUN.
  - RUN: each cycle adds the low BITS_PER_CYCLE bits of A, B and carry. A and B shift right by BITS_PER_CYCLE. The partial sum shifts into the top of the sum register. Carry-out of the slice updates the carry register. The counter decrements, and the beat at counter=0 transitions to DONE.
  - DONE: out_valid=1. sum, cout and ovf are held stable. The output handshake (out_valid & out_ready) moves the FSM to IDLE.
- in_valid is ignored outside IDLE. Operand inputs need only be stable on the accepting edge.
- cout is the carry out of bit WIDTH−1 on the final beat.
- Outputs are stable from DONE entry until the handshake. After the handshake, sum and cout keep their last value, but out_valid=0.
- Reset, whether idle or mid-operation, aborts any operation with no partial result emitted. The FSM enters IDLE with in_ready=1, out_valid=0, sum=0, cout=0 and ovf=0. The shift registers, carry register and counter are cleared.

## Timing
- Acceptance on edge 0. Beats execute on edges 1..N. out_valid is high after edge N.
- If out_ready is already high, the output handshake happens on edge N+1 and in_ready is high again after edge N+1. The next acceptance is possible on edge N+2.
- Maximum throughput is one operation per N+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with in_ready=0.
- There is no combinational path from in_valid or out_ready to any output. in_ready and out_valid are pure state decodes.

## Configuration
- SERIAL_ADDER_OVF_EN defined: ovf port exists. The block keeps the carry into bit WIDTH−1 from the final beat and sets ovf = carry_into_msb ^ cout at DONE entry. ovf is valid with out_valid and resets to 0.
- SERIAL_ADDER_OVF_EN undefined: no ovf port and no MSB-carry tracking logic.

## Test plan
- WIDTH=8, BPC=1, out_ready=1, a=8'h5A, b=8'h3C, cin=1, sub=0 -> out_valid rises 8 cycles after acceptance with sum=8'h97, cout=0; in_ready returns after 9 cycles.
- WIDTH=8, BPC=1, wrap and overflow cases:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
  - a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
  - sub=1, a=8'h10, b=8'h20 -> sum=8'hF0, cout=0 (borrow).
- WIDTH=16, BPC=4, a=16'hFFFF, b=16'h0001, cin=0 -> out_valid after 4 cycles, sum=16'h0000, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and operands -> sum and cout stay constant, in_ready=0, no new capture. Release out_ready -> single handshake, then IDLE.
- Reset mid-op: drop rst_n for one edge during beat 3 of an 8-beat operation -> out_valid=0, sum=0, cout=0, in_ready=1. The next operation, 8'h01+8'h01, gives sum=8'h02.
- WIDTH=1, BPC=1 exhaustive: all 8 {a,b,cin} combinations with sub=0 -> {cout,sum} equals a+b+cin, each result after 1 beat.
